multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
// - Multi-cycle successor to the single-cycle RV32I control decoder.
// - Sequences FETCH/DECODE/EXEC/MEM/WB, handshakes with instruction/data memory and the MMIO bus,
//   and generates byte-lane enables for sub-word loads/stores.
// - Traps on illegal opcodes, misaligned accesses and bus timeouts.
// - Sits between the IR/datapath and the memory/IO arbiter.
// PARAMETERS
// - IO_MASK    32'hFFFF_F000  address bits compared for MMIO decode
// - IO_MATCH   32'hFFFF_F000  addr is IO when (addr & IO_MASK) == IO_MATCH
// - TIMEOUT    16             max wait cycles for any ack before trap (>=2)
// PORTS
// - clk            in   1   system clock, rising edge
// - rst            in   1   synchronous reset, active-high
// - inst           in   32  IR contents; valid from DECODE onward
// - alu_result     in   32  ALU output; the load/store address in EXEC/MEM
// - branch_taken   in   1   ALU compare result; valid in EXEC
// - mem_ack        in   1   memory completes fetch or data access this cycle
// - io_ack         in   1   MMIO completes access this cycle
// - state          out  3   current FSM state (debug)
// - ir_write       out  1   latch fetched word into IR
// - pc_write       out  1   update PC, once per instruction
// - pc_sel         out  2   0 PC+4, 1 branch target, 2 JAL target, 3 JALR target
// - reg_write      out  1   write rd
// - wb_sel         out  2   0 ALU, 1 load data, 2 PC+4, 3 U-immediate
// - alu_src        out  1   1 = immediate operand
// - alu_op         out  2   00 add, 01 branch compare, 10 R-type funct, 11 auipc
// - mem_req/mem_we out  1+1 memory request / write
// - io_req/io_we   out  1+1 MMIO request / write
// - byte_en        out  4   store lane enables / load lane select
// - load_size      out  2   0 byte, 1 half, 2 word
// - load_unsigned  out  1   lbu/lhu
// - illegal        out  1   sticky: unsupported opcode or funct3
// - misaligned     out  1   sticky: misaligned half/word access
// - bus_timeout    out  1   sticky: ack not received within TIMEOUT cycles
// BEHAVIOUR
// - Reset: every output is 0 while rst=1. The next state is FETCH, the wait counter is 0 and the sticky flags are cleared.
//   Reset overrides any state, including an outstanding request; the request is dropped with no completion.
// - FETCH: mem_req=1, mem_we=0, byte_en=1111.
//   - On mem_ack: ir_write=1 and go to DECODE.
//   - Otherwise stay and increment the wait counter.
// - DECODE: classify inst.
//   - Unsupported opcode or funct3: go to TRAP and set illegal.
//   - Otherwise go to EXEC.
// - EXEC: drive alu_src/alu_op.
//   - Branch: pc_write=1, pc_sel = branch_taken ? 1 : 0; next state FETCH (3 cycles total).
//   - Load/store: check alignment of alu_result. Misaligned (half with addr[0]=1, word with addr[1:0]!=0)
//     goes to TRAP and sets misaligned. Otherwise go to MEM.
//   - All other instructions: go to WB.
// - MEM: address is IO when the IO_MASK/IO_MATCH compare hits.
//   - IO access drives io_req/io_we; non-IO access drives mem_req/mem_we. The two requests are never both high.
//   - Request is held until the matching ack. Loads then go to WB.
//   - Stores: pc_write=1, pc_sel=0 in the ack cycle, then FETCH.
// - WB: reg_write=1 and pc_write=1, then FETCH.
//   - wb_sel: ALU for R/I-type, load data for loads, PC+4 for jal/jalr, U-imm for lui (auipc uses ALU).
//   - pc_sel: 2 for jal, 3 for jalr, else 0.
// - TRAP: all request, write and enable outputs are 0. Sticky flags are held. Only rst leaves TRAP.
// - Byte lanes:
//   - sb/lb/lbu: 0001 << addr[1:0].
//   - sh/lh/lhu: 0011 << {addr[1],1'b0}.
//   - sw/lw: 1111.
//   - Outside FETCH/MEM: 0000.
// - Wait counter:
//   - Cleared on entry to FETCH/MEM and on any ack.
//   - When it reaches TIMEOUT-1 without an ack, set bus_timeout and go to TRAP.
//   - An ack in that same cycle wins: no trap.
// - Nominal latency with zero-wait acks:
//   - ALU/U-type/jump: 4 cycles.
//   - Load: 5 cycles.
//   - Store: 4 cycles.
//   - Branch: 3 cycles.
// STRUCTURE
// - Package rv_ctrl_pkg: opcode constants, state encoding (FETCH..TRAP), alu_op, wb_sel and pc_sel codes.
// - Sub-module ctrl_decode (combinational): inst -> instruction class, size, unsigned and legal flags.
//   The FSM, wait counter and lane logic live in the top module.
// TESTING
// - addi x1,x0,5 (0x00500093) with mem_ack tied 1 -> states FETCH,DECODE,EXEC,WB.
//   alu_src=1 in EXEC; reg_write=1 and wb_sel=0 only in WB; exactly one pc_write.
// - sw to alu_result=0xFFFF_F004, io_ack after 3 cycles -> io_req=io_we=1, byte_en=1111, mem_req=0.
//   MEM lasts 4 cycles; pc_write in the ack cycle.
// - sb at 0x13 -> byte_en=1000. sh at 0x2 -> byte_en=1100.
//   lh at 0x1 -> TRAP, misaligned=1, no mem_req.
// - beq with branch_taken=1 -> pc_write=1, pc_sel=1 in EXEC; reg_write never 1; back to FETCH.
// - lw with mem_ack held 0 in MEM -> bus_timeout=1 after TIMEOUT(16) cycles, then TRAP.
//   With ack in cycle 16, the load completes normally.
// - inst=0xFFFFFFFF -> illegal=1, TRAP.
//   rst pulsed mid-MEM of an earlier lw -> all outputs 0 during rst.
//   Next cycle: FETCH, mem_req=1, flags cleared.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, FSM states,
// instruction classes, mux select codes and byte-lane helpers.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CL_REG, CL_IMM, CL_LUI, CL_AUIPC, CL_JAL, CL_JALR, CL_BRANCH, CL_LOAD, CL_STORE
    } class_e;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_BR    = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_AUIPC = 2'b11;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;
    localparam logic [1:0] WB_UIMM = 2'd3;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JAL    = 2'd2;
    localparam logic [1:0] PC_JALR   = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr);
        case (size)
            SZ_BYTE: return 4'b0001 << addr;
            SZ_HALF: return 4'b0011 << {addr[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
        return ((size == SZ_HALF) && addr[0]) || ((size == SZ_WORD) && (addr != 2'b00));
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: opcode/funct3 -> class, access size,
// unsigned-load flag and legality.
module ctrl_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    output class_e     cls_o,
    output logic [1:0] size_o,
    output logic       unsigned_o,
    output logic       legal_o
);

    always_comb begin
        cls_o      = CL_REG;
        size_o     = funct3_i[1:0];
        unsigned_o = 1'b0;
        legal_o    = 1'b1;
        case (opcode_i)
            OP_LUI:    cls_o = CL_LUI;
            OP_AUIPC:  cls_o = CL_AUIPC;
            OP_JAL:    cls_o = CL_JAL;
            OP_JALR: begin
                cls_o   = CL_JALR;
                legal_o = (funct3_i == 3'b000);
            end
            OP_BRANCH: begin
                cls_o   = CL_BRANCH;
                legal_o = (funct3_i[2:1] != 2'b01);
            end
            OP_LOAD: begin
                // lb/lh/lw/lbu/lhu only
                cls_o      = CL_LOAD;
                unsigned_o = funct3_i[2];
                legal_o    = (funct3_i[1:0] != 2'b11) && (funct3_i != 3'b110);
            end
            OP_STORE: begin
                cls_o   = CL_STORE;
                legal_o = !funct3_i[2] && (funct3_i[1:0] != 2'b11);
            end
            OP_IMM:    cls_o = CL_IMM;
            OP_REG:    cls_o = CL_REG;
            default:   legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I controller: FETCH/DECODE/EXEC/MEM/WB sequencing, memory and
// MMIO handshakes, byte-lane generation, and sticky trap flags.
module multicycle_controller
    import rv_ctrl_pkg::*;
#(
    parameter logic [31:0] IO_MASK  = 32'hFFFF_F000,
    parameter logic [31:0] IO_MATCH = 32'hFFFF_F000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic [31:0] alu_result,
    input  logic        branch_taken,
    input  logic        mem_ack,
    input  logic        io_ack,
    output logic [2:0]  state,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_sel,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        mem_req,
    output logic        mem_we,
    output logic        io_req,
    output logic        io_we,
    output logic [3:0]  byte_en,
    output logic [1:0]  load_size,
    output logic        load_unsigned,
    output logic        illegal,
    output logic        misaligned,
    output logic        bus_timeout
);

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [15:0] wait_q, wait_d;
    logic        illegal_q, illegal_d;
    logic        misaligned_q, misaligned_d;
    logic        timeout_q, timeout_d;

    class_e      cls;
    logic [1:0]  size;
    logic        is_unsigned;
    logic        legal;
    logic        is_io;
    logic        data_ack;
    logic        alu_src_c;
    logic [1:0]  alu_op_c;
    logic        unused_inst;

    assign unused_inst = ^{inst[31:15], inst[11:7]};

    ctrl_decode u_decode (
        .opcode_i   (inst[6:0]),
        .funct3_i   (inst[14:12]),
        .cls_o      (cls),
        .size_o     (size),
        .unsigned_o (is_unsigned),
        .legal_o    (legal)
    );

    assign is_io    = (alu_result & IO_MASK) == IO_MATCH;
    assign data_ack = is_io ? io_ack : mem_ack;

    always_comb begin
        alu_src_c = 1'b1;
        alu_op_c  = ALU_ADD;
        case (cls)
            CL_REG:    begin alu_src_c = 1'b0; alu_op_c = ALU_FUNCT; end
            CL_IMM:    alu_op_c = ALU_FUNCT;
            CL_AUIPC:  alu_op_c = ALU_AUIPC;
            CL_BRANCH: begin alu_src_c = 1'b0; alu_op_c = ALU_BR; end
            default:   ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        illegal_d     = illegal_q;
        misaligned_d  = misaligned_q;
        timeout_d     = timeout_q;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_sel        = PC_PLUS4;
        reg_write     = 1'b0;
        wb_sel        = WB_ALU;
        alu_src       = 1'b0;
        alu_op        = ALU_ADD;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        io_req        = 1'b0;
        io_we         = 1'b0;
        byte_en       = 4'b0000;
        load_size     = SZ_BYTE;
        load_unsigned = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                byte_en = 4'b1111;
                if (mem_ack) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_DECODE: begin
                if (!legal) begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_src = alu_src_c;
                alu_op  = alu_op_c;
                if (cls == CL_BRANCH) begin
                    pc_write = 1'b1;
                    pc_sel   = branch_taken ? PC_BRANCH : PC_PLUS4;
                    state_d  = S_FETCH;
                end else if (cls == CL_LOAD || cls == CL_STORE) begin
                    if (is_misaligned(size, alu_result[1:0])) begin
                        misaligned_d = 1'b1;
                        state_d      = S_TRAP;
                    end else begin
                        state_d = S_MEM;
                    end
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                // ALU stays configured so alu_result keeps presenting the address
                alu_src = alu_src_c;
                alu_op  = alu_op_c;
                byte_en = lane_mask(size, alu_result[1:0]);
                if (is_io) begin
                    io_req = 1'b1;
                    io_we  = (cls == CL_STORE);
                end else begin
                    mem_req = 1'b1;
                    mem_we  = (cls == CL_STORE);
                end
                if (cls == CL_LOAD) begin
                    load_size     = size;
                    load_unsigned = is_unsigned;
                end
                if (data_ack) begin
                    if (cls == CL_STORE) begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_WB: begin
                alu_src   = alu_src_c;
                alu_op    = alu_op_c;
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_d   = S_FETCH;
                case (cls)
                    CL_LOAD: begin
                        wb_sel        = WB_LOAD;
                        load_size     = size;
                        load_unsigned = is_unsigned;
                    end
                    CL_JAL:  begin wb_sel = WB_PC4; pc_sel = PC_JAL; end
                    CL_JALR: begin wb_sel = WB_PC4; pc_sel = PC_JALR; end
                    CL_LUI:  wb_sel = WB_UIMM;
                    default: ;
                endcase
            end
            S_TRAP:  ;
            default: state_d = S_TRAP;
        endcase

        // Counter restarts on every state change (which every ack causes)
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (state_q == S_FETCH || state_q == S_MEM) begin
            wait_d = wait_q + 16'd1;
        end

        if (rst) begin
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_sel        = 2'd0;
            reg_write     = 1'b0;
            wb_sel        = 2'd0;
            alu_src       = 1'b0;
            alu_op        = 2'd0;
            mem_req       = 1'b0;
            mem_we        = 1'b0;
            io_req        = 1'b0;
            io_we         = 1'b0;
            byte_en       = 4'b0000;
            load_size     = 2'd0;
            load_unsigned = 1'b0;
        end
    end

    assign state       = rst ? 3'b000 : state_q;
    assign illegal     = illegal_q & ~rst;
    assign misaligned  = misaligned_q & ~rst;
    assign bus_timeout = timeout_q & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            wait_q       <= '0;
            illegal_q    <= 1'b0;
            misaligned_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            illegal_q    <= illegal_d;
            misaligned_q <= misaligned_d;
            timeout_q    <= timeout_d;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst = 32'h0;
    logic [31:0] alu_result = 32'h0;
    logic        branch_taken = 1'b0;
    logic        mem_ack = 1'b0;
    logic        io_ack = 1'b0;
    logic [2:0]  state;
    logic        ir_write, pc_write, reg_write, alu_src;
    logic [1:0]  pc_sel, wb_sel, alu_op, load_size;
    logic        mem_req, mem_we, io_req, io_we, load_unsigned;
    logic [3:0]  byte_en;
    logic        illegal, misaligned, bus_timeout;
    logic [26:0] all_out;

    int errors = 0;
    int checks = 0;

    assign all_out = {state, ir_write, pc_write, pc_sel, reg_write, wb_sel, alu_src, alu_op,
                      mem_req, mem_we, io_req, io_we, byte_en, load_size, load_unsigned,
                      illegal, misaligned, bus_timeout};

    multicycle_controller #(
        .IO_MASK  (32'hFFFF_F000),
        .IO_MATCH (32'hFFFF_F000),
        .TIMEOUT  (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .inst          (inst),
        .alu_result    (alu_result),
        .branch_taken  (branch_taken),
        .mem_ack       (mem_ack),
        .io_ack        (io_ack),
        .state         (state),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_sel        (pc_sel),
        .reg_write     (reg_write),
        .wb_sel        (wb_sel),
        .alu_src       (alu_src),
        .alu_op        (alu_op),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .io_req        (io_req),
        .io_we         (io_we),
        .byte_en       (byte_en),
        .load_size     (load_size),
        .load_unsigned (load_unsigned),
        .illegal       (illegal),
        .misaligned    (misaligned),
        .bus_timeout   (bus_timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ack = 1'b0;
        io_ack = 1'b0;
        branch_taken = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_ack = 1'b1;
        io_ack = 1'b1;
        inst = 32'h0050_0093;
        @(negedge clk);
        checks++;
        if (all_out !== 27'd0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
        step();
        rst = 1'b0;
        mem_ack = 1'b0;
        io_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++;
        if ({mem_req, mem_we, byte_en} !== 6'b10_1111) begin errors++; $display("FAIL reset_fetch_req: got %b expected 101111", {mem_req, mem_we, byte_en}); end
        checks++;
        if ({illegal, misaligned, bus_timeout} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {illegal, misaligned, bus_timeout}); end
    endtask

    task automatic test_addi();
        logic [2:0] exp_st [4];
        int n_pc;
        int n_rw;
        exp_st = '{3'd0, 3'd1, 3'd2, 3'd4};
        n_pc = 0;
        n_rw = 0;
        do_reset();
        inst = 32'h0050_0093;
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (state !== exp_st[i]) begin errors++; $display("FAIL addi_state[%0d]: got %0d expected %0d", i, state, exp_st[i]); end
            if (pc_write) n_pc++;
            if (reg_write) n_rw++;
            if (i == 0) begin
                checks++;
                if (ir_write !== 1'b1) begin errors++; $display("FAIL addi_ir_write: got %b expected 1", ir_write); end
            end
            if (i == 2) begin
                checks++;
                if (alu_src !== 1'b1) begin errors++; $display("FAIL addi_alu_src: got %b expected 1", alu_src); end
            end
            if (i == 3) begin
                checks++;
                if ({reg_write, wb_sel} !== 3'b100) begin errors++; $display("FAIL addi_wb: got %b expected 100", {reg_write, wb_sel}); end
            end
            step();
        end
        checks++;
        if (n_pc != 1) begin errors++; $display("FAIL addi_pc_write_count: got %0d expected 1", n_pc); end
        checks++;
        if (n_rw != 1) begin errors++; $display("FAIL addi_reg_write_count: got %0d expected 1", n_rw); end
        @(negedge clk);
        checks++;
        if (state !== 3'd0) begin errors++; $display("FAIL addi_back_to_fetch: got %0d expected 0", state); end
    endtask

    task automatic test_sw_io();
        do_reset();
        inst = 32'h0020_A223;
        alu_result = 32'hFFFF_F004;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        step();
        step();
        for (int k = 1; k <= 4; k++) begin
            io_ack = (k == 4);
            @(negedge clk);
            checks++;
            if (state !== 3'd3) begin errors++; $display("FAIL sw_mem_state[%0d]: got %0d expected 3", k, state); end
            if (k == 1) begin
                checks++;
                if ({io_req, io_we, mem_req, byte_en} !== 7'b110_1111) begin
                    errors++; $display("FAIL sw_io_req: got %b expected 1101111", {io_req, io_we, mem_req, byte_en});
                end
                checks++;
                if (pc_write !== 1'b0) begin errors++; $display("FAIL sw_early_pc_write: got %b expected 0", pc_write); end
            end
            if (k == 4) begin
                checks++;
                if ({pc_write, pc_sel} !== 3'b100) begin errors++; $display("FAIL sw_ack_pc: got %b expected 100", {pc_write, pc_sel}); end
            end
            step();
        end
        io_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 3'd0) begin errors++; $display("FAIL sw_back_to_fetch: got %0d expected 0", state); end
    endtask

    task automatic test_lanes();
        do_reset();
        mem_ack = 1'b1;
        inst = 32'h0000_0023;
        alu_result = 32'h0000_0013;
        step(); step(); step();
        @(negedge clk);
        checks++;
        if ({state, mem_req, mem_we, byte_en} !== 9'b011_11_1000) begin
            errors++; $display("FAIL sb_lanes: got %b expected 011111000", {state, mem_req, mem_we, byte_en});
        end
        step();
        inst = 32'h0000_1023;
        alu_result = 32'h0000_0002;
        step(); step(); step();
        @(negedge clk);
        checks++;
        if ({state, byte_en} !== 7'b011_1100) begin errors++; $display("FAIL sh_lanes: got %b expected 0111100", {state, byte_en}); end
        step();
        inst = 32'h0000_1003;
        alu_result = 32'h0000_0001;
        step(); step();
        @(negedge clk);
        checks++;
        if ({state, mem_req} !== 4'b010_0) begin errors++; $display("FAIL lh_exec: got %b expected 0100", {state, mem_req}); end
        step();
        @(negedge clk);
        checks++;
        if ({state, misaligned, mem_req, byte_en} !== 9'b101_1_0_0000) begin
            errors++; $display("FAIL lh_trap: got %b expected 101100000", {state, misaligned, mem_req, byte_en});
        end
        step(); step(); step();
        @(negedge clk);
        checks++;
        if ({state, misaligned} !== 4'b101_1) begin errors++; $display("FAIL trap_sticky: got %b expected 1011", {state, misaligned}); end

        do_reset();
        mem_ack = 1'b1;
        inst = 32'h0000_4003;
        alu_result = 32'h0000_0022;
        step(); step(); step();
        @(negedge clk);
        checks++;
        if ({byte_en, load_size, load_unsigned, mem_we} !== 8'b0100_00_1_0) begin
            errors++; $display("FAIL lbu_mem: got %b expected 01000010", {byte_en, load_size, load_unsigned, mem_we});
        end
        step();
        @(negedge clk);
        checks++;
        if ({state, reg_write, wb_sel, byte_en} !== 10'b100_1_01_0000) begin
            errors++; $display("FAIL lbu_wb: got %b expected 1001010000", {state, reg_write, wb_sel, byte_en});
        end
    endtask

    task automatic test_branch();
        int n_rw;
        n_rw = 0;
        do_reset();
        inst = 32'h0000_0063;
        branch_taken = 1'b1;
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (reg_write) n_rw++;
            if (i == 2) begin
                checks++;
                if ({state, pc_write, pc_sel, alu_op} !== 8'b010_1_01_01) begin
                    errors++; $display("FAIL beq_taken_exec: got %b expected 01010101", {state, pc_write, pc_sel, alu_op});
                end
            end
            step();
        end
        @(negedge clk);
        checks++;
        if (state !== 3'd0) begin errors++; $display("FAIL beq_back_to_fetch: got %0d expected 0", state); end
        checks++;
        if (n_rw != 0) begin errors++; $display("FAIL beq_reg_write: got %0d expected 0", n_rw); end
        branch_taken = 1'b0;
        step(); step();
        @(negedge clk);
        checks++;
        if ({state, pc_write, pc_sel} !== 6'b010_1_00) begin
            errors++; $display("FAIL beq_not_taken: got %b expected 010100", {state, pc_write, pc_sel});
        end
    endtask

    task automatic test_wb_sel();
        logic [31:0] t_inst [4];
        logic [1:0]  t_wb [4];
        logic [1:0]  t_pc [4];
        t_inst = '{32'h0000_006F, 32'h0000_0067, 32'h0000_0037, 32'h0000_0017};
        t_wb   = '{2'd2, 2'd2, 2'd3, 2'd0};
        t_pc   = '{2'd2, 2'd3, 2'd0, 2'd0};
        do_reset();
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inst = t_inst[i];
            step(); step(); step();
            @(negedge clk);
            checks++;
            if ({state, wb_sel, pc_sel, pc_write} !== {3'd4, t_wb[i], t_pc[i], 1'b1}) begin
                errors++; $display("FAIL wb_sel[%0d]: got %b expected %b", i, {state, wb_sel, pc_sel, pc_write}, {3'd4, t_wb[i], t_pc[i], 1'b1});
            end
            step();
        end
    endtask

    task automatic test_timeout();
        for (int p = 0; p < 2; p++) begin
            do_reset();
            inst = 32'h0000_2003;
            alu_result = 32'h0000_0100;
            mem_ack = 1'b1;
            step();
            mem_ack = 1'b0;
            step();
            step();
            for (int k = 1; k <= 16; k++) begin
                mem_ack = (p == 1) && (k == 16);
                @(negedge clk);
                if (k == 1) begin
                    checks++;
                    if ({state, mem_req, io_req} !== 5'b011_1_0) begin errors++; $display("FAIL lw_mem_req[%0d]: got %b expected 01110", p, {state, mem_req, io_req}); end
                end
                if (k == 16) begin
                    checks++;
                    if ({state, bus_timeout} !== 4'b011_0) begin errors++; $display("FAIL lw_wait16[%0d]: got %b expected 0110", p, {state, bus_timeout}); end
                end
                step();
            end
            mem_ack = 1'b0;
            @(negedge clk);
            checks++;
            if (p == 0) begin
                if ({state, bus_timeout, mem_req} !== 5'b101_1_0) begin errors++; $display("FAIL lw_timeout_trap: got %b expected 10110", {state, bus_timeout, mem_req}); end
            end else begin
                if ({state, bus_timeout, reg_write, wb_sel} !== 7'b100_0_1_01) begin
                    errors++; $display("FAIL lw_late_ack: got %b expected 1000101", {state, bus_timeout, reg_write, wb_sel});
                end
            end
        end
    endtask

    task automatic test_illegal_reset();
        do_reset();
        inst = 32'hFFFF_FFFF;
        mem_ack = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if ({state, illegal} !== 4'b001_0) begin errors++; $display("FAIL illegal_decode: got %b expected 0010", {state, illegal}); end
        step();
        @(negedge clk);
        checks++;
        if ({state, illegal, mem_req, ir_write} !== 6'b101_1_0_0) begin
            errors++; $display("FAIL illegal_trap: got %b expected 101100", {state, illegal, mem_req, ir_write});
        end
        rst = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (all_out !== 27'd0) begin errors++; $display("FAIL trap_reset_outputs: got %h expected 0", all_out); end
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({state, illegal, mem_req} !== 5'b000_0_1) begin errors++; $display("FAIL trap_reset_exit: got %b expected 00001", {state, illegal, mem_req}); end

        inst = 32'h0000_2003;
        alu_result = 32'h0000_0200;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        step();
        step();
        @(negedge clk);
        checks++;
        if ({state, mem_req} !== 4'b011_1) begin errors++; $display("FAIL lw_mid_mem: got %b expected 0111", {state, mem_req}); end
        step();
        rst = 1'b1;
        mem_ack = 1'b1;
        io_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (all_out !== 27'd0) begin errors++; $display("FAIL mem_reset_outputs: got %h expected 0", all_out); end
        step();
        rst = 1'b0;
        mem_ack = 1'b0;
        io_ack = 1'b0;
        @(negedge clk);
        checks++;
        if ({state, mem_req, byte_en, illegal, misaligned, bus_timeout} !== 11'b000_1_1111_000) begin
            errors++; $display("FAIL mem_reset_exit: got %b expected 00011111000", {state, mem_req, byte_en, illegal, misaligned, bus_timeout});
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_sw_io();
        test_lanes();
        test_branch();
        test_wb_sel();
        test_timeout();
        test_illegal_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
